// File: rtl/uart_port_scheduler.sv
// Shares one uart core among NUM_REQ transmit requesters (round-robin) and owns the
// receive side: captures each received byte once and offers it on a valid/ready port.
module uart_port_scheduler #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = 16,
  localparam int unsigned IDW         = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [IDW-1:0]       tx_owner,
  output logic                 tx_active,
  output logic                 tx_timeout,
  output logic [7:0]           uart_data_send,
  output logic                 uart_wr_en,
  input  logic                 uart_tx_busy,
  input  logic                 uart_rdy,
  output logic                 uart_rdy_clr,
  input  logic [7:0]           uart_received_data,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun
);

  localparam int unsigned   CW      = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] CntLast = CW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {TxIdle, TxWaitBusy, TxWaitDone} tx_state_e;
  typedef enum logic {RxIdle, RxClr} rx_state_e;

  tx_state_e tx_state_q, tx_state_d;
  rx_state_e rx_state_q, rx_state_d;

  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [IDW-1:0]     tx_owner_q, tx_owner_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [7:0]         data_send_q, data_send_d;
  logic               wr_en_q, wr_en_d;
  logic               timeout_q, timeout_d;
  logic               active_q, active_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rdy_clr_q, rdy_clr_d;
  logic               overrun_q, overrun_d;

  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [IDW-1:0]     cand;

  // (base + off) mod NUM_REQ without a general divider; off is always < NUM_REQ here
  function automatic logic [IDW-1:0] rot_idx(input logic [IDW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDW'(sum);
  endfunction

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = rot_idx(rr_ptr_q, k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TxIdle;
      req_ready_q <= '0;
      tx_owner_q  <= '0;
      rr_ptr_q    <= '0;
      data_send_q <= '0;
      wr_en_q     <= 1'b0;
      timeout_q   <= 1'b0;
      active_q    <= 1'b0;
      cnt_q       <= '0;
      rx_state_q  <= RxIdle;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rdy_clr_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      req_ready_q <= req_ready_d;
      tx_owner_q  <= tx_owner_d;
      rr_ptr_q    <= rr_ptr_d;
      data_send_q <= data_send_d;
      wr_en_q     <= wr_en_d;
      timeout_q   <= timeout_d;
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      rx_state_q  <= rx_state_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rdy_clr_q   <= rdy_clr_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      TxIdle:     if (grant_found) tx_state_d = TxWaitBusy;
      TxWaitBusy: begin
        if (uart_tx_busy)          tx_state_d = TxWaitDone;
        else if (cnt_q == CntLast) tx_state_d = TxIdle;
      end
      TxWaitDone: if (!uart_tx_busy) tx_state_d = TxIdle;
      default:    tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    req_ready_d = '0;
    wr_en_d     = 1'b0;
    timeout_d   = 1'b0;
    tx_owner_d  = tx_owner_q;
    data_send_d = data_send_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    unique case (tx_state_q)
      TxIdle: begin
        if (grant_found) begin
          req_ready_d = NUM_REQ'(1) << grant_idx;
          wr_en_d     = 1'b1;
          tx_owner_d  = grant_idx;
          data_send_d = req_data[{grant_idx, 3'b000} +: 8];
          rr_ptr_d    = rot_idx(grant_idx, 1);
          cnt_d       = '0;
        end
      end
      TxWaitBusy: begin
        if (!uart_tx_busy) begin
          if (cnt_q == CntLast) timeout_d = 1'b1;
          else                  cnt_d     = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    active_d = (tx_state_d != TxIdle);
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RxIdle:  if (uart_rdy) rx_state_d = RxClr;
      RxClr:   if (!uart_rdy) rx_state_d = RxIdle;
      default: rx_state_d = RxIdle;
    endcase
  end

  // A capture in the same cycle as an accept replaces the byte without flagging overrun
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q && !rx_ready;
    rdy_clr_d  = rdy_clr_q;
    overrun_d  = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (uart_rdy) begin
          rx_data_d  = uart_received_data;
          rx_valid_d = 1'b1;
          rdy_clr_d  = 1'b1;
          overrun_d  = rx_valid_q && !rx_ready;
        end
      end
      RxClr:   if (!uart_rdy) rdy_clr_d = 1'b0;
      default: ;
    endcase
  end

  assign req_ready      = req_ready_q;
  assign tx_owner       = tx_owner_q;
  assign tx_active      = active_q;
  assign tx_timeout     = timeout_q;
  assign uart_data_send = data_send_q;
  assign uart_wr_en     = wr_en_q;
  assign uart_rdy_clr   = rdy_clr_q;
  assign rx_data        = rx_data_q;
  assign rx_valid       = rx_valid_q;
  assign rx_overrun     = overrun_q;

endmodule

// File: tb/tb_uart_port_scheduler.sv
// Bench for uart_port_scheduler: a bench-side uart core (loopback / busy-stuck / direct
// receive injection), a cycle model of the scheduler's rules, and directed scenarios.
module tb_uart_port_scheduler;
  localparam int NUM_REQ = 4;
  localparam int BT      = 16;
  localparam int IDW     = 2;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [IDW-1:0]       tx_owner;
  logic                 tx_active, tx_timeout, uart_wr_en, uart_tx_busy, uart_rdy, uart_rdy_clr;
  logic [7:0]           uart_data_send, uart_received_data, rx_data;
  logic                 rx_valid, rx_ready, rx_overrun;

  always #5 clk = ~clk;

  uart_port_scheduler #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_owner(tx_owner), .tx_active(tx_active),
    .tx_timeout(tx_timeout), .uart_data_send(uart_data_send), .uart_wr_en(uart_wr_en),
    .uart_tx_busy(uart_tx_busy), .uart_rdy(uart_rdy), .uart_rdy_clr(uart_rdy_clr),
    .uart_received_data(uart_received_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_overrun(rx_overrun)
  );

  int total, bad, cyc;
  logic [7:0] rq [NUM_REQ][$];
  logic [7:0] rx_log [$];
  int         g_own [$];
  logic [7:0] g_dat [$];
  int rr_pulses, to_cnt, to_cyc, wr_cyc, ov_cnt, inj_cnt, inj_done, u_cnt;
  logic to_active, tie_busy0;
  logic [7:0] inj_byte, u_hold;

  // model state: expected outputs for the cycle after each edge
  int m_ptr, m_since, g;
  logic m_in_tx, m_busy_seen, m_clr, acc;
  logic [NUM_REQ-1:0] e_req_ready;
  logic [IDW-1:0] e_owner;
  logic [7:0] e_data, e_rx_data;
  logic e_wr_en, e_timeout, e_active, e_rdy_clr, e_rx_valid, e_overrun;
  logic [27:0] a_vec, e_vec;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [27:0] out_vec();
    return {req_ready, tx_owner, uart_data_send, uart_wr_en, tx_timeout, tx_active,
            uart_rdy_clr, rx_data, rx_valid, rx_overrun};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_grants(input int n, input int budget, input string name);
    for (int b = 0; b < budget && g_own.size() < n; b++) step(1);
    chk(name, g_own.size(), n);
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    for (int b = 0; b < budget && rx_log.size() < n; b++) step(1);
    chk(name, rx_log.size(), n);
  endtask

  task automatic inject(input logic [7:0] b);
    inj_byte = b;
    inj_cnt++;
  endtask

  task automatic wait_rx_settled(input string name);
    int b;
    b = 0;
    step(1);
    while (!(uart_rdy == 1'b0 && uart_rdy_clr == 1'b0 && rx_valid == 1'b1) && b < 20) begin
      step(1);
      b++;
    end
    chk(name, int'(b < 20), 1);
  endtask

  task automatic clear_logs();
    rx_log.delete();
    g_own.delete();
    g_dat.delete();
  endtask

  initial begin
    int errs;
    total = 0; bad = 0; cyc = 0;
    rr_pulses = 0; to_cnt = 0; to_cyc = 0; wr_cyc = 0; ov_cnt = 0;
    inj_cnt = 0; inj_done = 0; u_cnt = 0; u_hold = '0; inj_byte = '0;
    tie_busy0 = 1'b0; to_active = 1'b0;
    req_valid = '0; req_data = '0; uart_tx_busy = 1'b0; uart_rdy = 1'b0;
    uart_received_data = '0; rx_ready = 1'b1;
    m_ptr = 0; m_since = 0; m_in_tx = 0; m_busy_seen = 0; m_clr = 0;
    e_req_ready = '0; e_owner = '0; e_data = '0; e_rx_data = '0;
    e_wr_en = 0; e_timeout = 0; e_active = 0; e_rdy_clr = 0; e_rx_valid = 0; e_overrun = 0;

    fork
      // spec-rule model, updated at each active edge from the inputs seen before it
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          m_ptr = 0; m_in_tx = 0; m_busy_seen = 0; m_since = 0; m_clr = 0;
          e_req_ready = '0; e_owner = '0; e_data = '0; e_rx_data = '0;
          e_wr_en = 0; e_timeout = 0; e_active = 0; e_rdy_clr = 0; e_rx_valid = 0;
          e_overrun = 0;
        end else begin
          cyc++;
          if (rx_valid && rx_ready) rx_log.push_back(rx_data);
          e_req_ready = '0; e_wr_en = 0; e_timeout = 0;
          if (!m_in_tx) begin
            g = -1;
            for (int k = 0; k < NUM_REQ; k++)
              if (g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
            if (g >= 0) begin
              e_req_ready[g] = 1'b1;
              e_wr_en = 1;
              e_owner = g[IDW-1:0];
              e_data = req_data[8*g +: 8];
              m_ptr = (g + 1) % NUM_REQ;
              m_in_tx = 1; m_busy_seen = 0; m_since = 0;
            end
          end else if (!m_busy_seen) begin
            if (uart_tx_busy) m_busy_seen = 1;
            else begin
              m_since++;
              if (m_since == BT) begin e_timeout = 1; m_in_tx = 0; end
            end
          end else if (!uart_tx_busy) m_in_tx = 0;
          e_active = m_in_tx;
          acc = e_rx_valid && rx_ready;
          e_overrun = 0;
          if (!m_clr) begin
            if (uart_rdy) begin
              e_overrun = e_rx_valid && !rx_ready;
              e_rx_data = uart_received_data;
              e_rx_valid = 1; e_rdy_clr = 1; m_clr = 1;
            end else if (acc) e_rx_valid = 0;
          end else begin
            if (acc) e_rx_valid = 0;
            if (!uart_rdy) begin e_rdy_clr = 0; m_clr = 0; end
          end
        end
      end
      // per-cycle comparison against the model
      forever begin
        @(negedge clk);
        if (rst_n) begin
          a_vec = out_vec();
          e_vec = {e_req_ready, e_owner, e_data, e_wr_en, e_timeout, e_active, e_rdy_clr,
                   e_rx_data, e_rx_valid, e_overrun};
          total++;
          if (a_vec !== e_vec) begin
            bad++;
            $display("FAIL cycle_cmp cyc=%0d got=%h want=%h", cyc, a_vec, e_vec);
          end
        end
      end
      // monitors, requester drivers and the uart core stand-in
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (req_ready != '0) begin
            g_own.push_back(int'(tx_owner));
            g_dat.push_back(uart_data_send);
            rr_pulses += $countones(req_ready);
          end
          if (uart_wr_en) wr_cyc = cyc;
          if (tx_timeout) begin to_cnt++; to_cyc = cyc; to_active = tx_active; end
          if (rx_overrun) ov_cnt++;
          for (int i = 0; i < NUM_REQ; i++)
            if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          req_valid[i] = rq[i].size() > 0;
          req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
        end
        if (!rst_n) begin
          uart_tx_busy = 0; uart_rdy = 0; u_cnt = 0; inj_done = inj_cnt;
        end else begin
          if (uart_rdy && uart_rdy_clr) uart_rdy = 0;
          if (inj_done != inj_cnt) begin
            inj_done = inj_cnt; uart_rdy = 1; uart_received_data = inj_byte;
          end
          if (tie_busy0) begin
            uart_tx_busy = 0; u_cnt = 0;
          end else if (uart_wr_en) begin
            u_hold = uart_data_send; u_cnt = 4; uart_tx_busy = 1;
          end else if (u_cnt > 0) begin
            u_cnt--;
            if (u_cnt == 0) begin
              uart_tx_busy = 0; uart_rdy = 1; uart_received_data = u_hold;
            end
          end
        end
      end
    join_none

    // reset state
    #1 rst_n = 1'b0;
    step(3);
    chk("reset_outputs", int'(out_vec()), 0);
    rst_n = 1'b1;
    step(1);

    // all four requesters valid: 0,1,2,3 then 0 again
    clear_logs();
    rq[0].push_back(8'hA0); rq[0].push_back(8'hA4);
    rq[1].push_back(8'hA1); rq[2].push_back(8'hA2); rq[3].push_back(8'hA3);
    wait_grants(5, 200, "rr_grant_count");
    for (int i = 0; i < 5; i++) begin
      chk("rr_owner", (g_own.size() > i) ? g_own[i] : -1, (i == 4) ? 0 : i);
      chk("rr_data", (g_dat.size() > i) ? int'(g_dat[i]) : -1, 'hA0 + i);
    end
    chk("rr_ready_pulses", rr_pulses, 5);
    wait_rx(5, 100, "rr_loopback_count");
    chk("rr_loopback_last", (rx_log.size() > 4) ? int'(rx_log[4]) : -1, 'hA4);

    // pointer driven to 3, then 3 and 0 both request: 3 wins, then wrap to 0
    clear_logs();
    rq[2].push_back(8'h33);
    wait_rx(1, 50, "wrap_setup_rx");
    step(2);
    rq[3].push_back(8'h3C); rq[0].push_back(8'h0C);
    wait_grants(3, 100, "wrap_grant_count");
    chk("wrap_first", (g_own.size() > 1) ? g_own[1] : -1, 3);
    chk("wrap_second", (g_own.size() > 2) ? g_own[2] : -1, 0);
    wait_rx(3, 100, "wrap_rx_count");

    // full loopback of 0x00..0xFF from requester 0
    step(3);
    clear_logs();
    for (int i = 0; i < 256; i++) rq[0].push_back(8'(i));
    wait_rx(256, 256 * 20, "loopback_count");
    errs = 0;
    for (int i = 0; i < 256; i++)
      if (i >= rx_log.size() || rx_log[i] != 8'(i)) errs++;
    chk("loopback_seq", errs, 0);
    chk("loopback_no_overrun", ov_cnt, 0);
    chk("loopback_no_timeout", to_cnt, 0);

    // busy never rises: timeout 16 cycles after the strobe, then service resumes
    step(3);
    clear_logs();
    tie_busy0 = 1'b1;
    rq[1].push_back(8'h77);
    for (int b = 0; b < 60 && to_cnt < 1; b++) step(1);
    chk("timeout_count", to_cnt, 1);
    chk("timeout_latency", to_cyc - wr_cyc, BT);
    chk("timeout_idle", int'(to_active), 0);
    tie_busy0 = 1'b0;
    rq[2].push_back(8'h5A);
    wait_grants(2, 50, "after_timeout_grants");
    chk("after_timeout_owner", (g_own.size() > 1) ? g_own[1] : -1, 2);
    wait_rx(1, 50, "after_timeout_rx");
    chk("after_timeout_byte", (rx_log.size() > 0) ? int'(rx_log[0]) : -1, 'h5A);

    // overrun: two bytes with no acceptance
    step(3);
    rx_ready = 1'b0;
    inject(8'h55);
    wait_rx_settled("ovr_first_settle");
    inject(8'hAA);
    wait_rx_settled("ovr_second_settle");
    chk("ovr_pulses", ov_cnt, 1);
    chk("ovr_data", int'(rx_data), 'hAA);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(1);
    // second byte lands on the same edge the first is accepted: no overrun
    inject(8'h11);
    wait_rx_settled("swap_first_settle");
    inject(8'h22);
    step(1);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    chk("swap_no_overrun", ov_cnt, 1);
    chk("swap_data", int'(rx_data), 'h22);
    chk("swap_valid", int'(rx_valid), 1);
    rx_ready = 1'b1;
    step(3);

    // reset in the middle of a transmit (waiting for busy to fall)
    rx_ready = 1'b0;
    rq[1].push_back(8'h99);
    for (int b = 0; b < 20 && !uart_tx_busy; b++) step(1);
    chk("rst_tx_busy_seen", int'(uart_tx_busy), 1);
    step(1);
    chk("rst_tx_in_wait_done", int'(tx_active), 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_tx_outputs", int'(out_vec()), 0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // reset while the receive side is holding rdy_clr
    inject(8'h42);
    for (int b = 0; b < 10 && !uart_rdy_clr; b++) step(1);
    chk("rst_rx_clr_seen", int'(uart_rdy_clr), 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_rx_outputs", int'(out_vec()), 0);
    step(2);
    rst_n = 1'b1;
    rx_ready = 1'b1;
    step(1);
    clear_logs();
    rq[3].push_back(8'hD3); rq[0].push_back(8'hD0);
    wait_grants(1, 20, "post_reset_grants");
    chk("post_reset_first", (g_own.size() > 0) ? g_own[0] : -1, 0);
    wait_rx(2, 100, "post_reset_rx");
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
